instr_fetch_stage: RTL and testbench

//  - Fetch stage directly downstream of program_counter: consumes pc_out, issues word reads to instruction memory.
//  - Buffers returned {pc, instr} pairs and presents them to decode over a valid/ready handshake.
//  - Emits pc_advance so the PC increments only when a fetch is accepted; branch_taken is the flush input.

---
 rtl/riscv_fetch_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 51 +++++
 rtl/instr_fetch_stage.sv | 133 +++++++++++++
 tb/tb_instr_fetch_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries between memory and decode.
module fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             entry,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(BUF_DEPTH):0] count,
    output fetch_entry_t             head
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is only consumed while count != 0.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC -> instruction memory -> buffer -> decode handshake.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned PCs instead of fetching.
module instr_fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    parameter int unsigned ADDR_W    = PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              pc_advance,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              id_misaligned
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e     state;
    fetch_state_e     state_nxt;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             slot_free;
    logic             misaligned;
    logic             hold;
    logic             hold_nxt;
    logic             load_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned    = pc_in[1:0] != 2'b00;
    assign id_misaligned = id_valid & head.misaligned;
`else
    logic unused_bits;
    assign misaligned  = 1'b0;
    assign unused_bits = ^{pc_in[1:0], head.misaligned};
`endif

    // Nothing is in flight while IDLE, so a free slot is just count < depth.
    assign slot_free  = count < CNT_W'(BUF_DEPTH);
    assign imem_req   = state == REQ;
    assign pc_advance = imem_req & imem_gnt & ~flush;
    assign pop        = id_valid & id_ready;

    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold;
        push       = 1'b0;
        load_addr  = 1'b0;
        push_entry = '{pc: PC_W'(imem_addr),
                       instr: imem_rdata,
                       misaligned: 1'b0};
        if (flush) begin
            hold_nxt = 1'b0;
            unique case (state)
                REQ:      state_nxt = imem_gnt ? DRAIN : IDLE;
                WAIT_RSP: state_nxt = imem_rvalid ? IDLE : DRAIN;
                DRAIN:    state_nxt = imem_rvalid ? IDLE : DRAIN;
                default:  state_nxt = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (slot_free && !hold) begin
                        if (misaligned) begin
                            push       = 1'b1;
                            hold_nxt   = 1'b1;
                            push_entry = '{pc: PC_W'(pc_in),
                                           instr: NOP_INSTR,
                                           misaligned: 1'b1};
                        end else begin
                            state_nxt = REQ;
                            load_addr = 1'b1;
                        end
                    end
                end
                REQ: if (imem_gnt) state_nxt = WAIT_RSP;
                WAIT_RSP: begin
                    if (imem_rvalid) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DRAIN: if (imem_rvalid) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= 1'b0;
            imem_addr <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            if (load_addr) imem_addr <= {pc_in[ADDR_W-1:2], 2'b00};
        end
    end

    fetch_buffer #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .entry(push_entry),
        .pop  (pop),
        .clear(flush),
        .count(count),
        .head (head)
    );

    assign id_valid = count != '0;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? ADDR_W'(head.pc) : '0;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a queue-based reference model.
module tb_instr_fetch_stage;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        flush;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        id_misaligned;
`endif

    always #5 clk = ~clk;

    instr_fetch_stage #(.BUF_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .flush      (flush),
        .pc_advance (pc_advance),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .id_misaligned(id_misaligned)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int total = 0;
    int bad   = 0;

    exp_t        q[$];
    logic [31:0] seen_pc[$];
    logic [31:0] seen_instr[$];
    int          seen_cyc[$];

    int          gnt_delay, rsp_delay;
    logic [31:0] flush_target;
    logic        mon_en;
    logic [31:0] pc_reg = '0;
    int          cyc = 0;
    int          req_age = 0;
    logic        pend = 0, pend_live = 0;
    int          pend_age = 0, pend_delay = 1;
    logic [31:0] pend_addr = '0;
    int          adv_count, gnt_count, req_cycles;
    int          first_gnt, first_valid, last_req_len;
    logic [31:0] last_gnt_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], 16'h0113};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    task automatic clear_logs();
        seen_pc.delete();
        seen_instr.delete();
        seen_cyc.delete();
        adv_count   = 0;
        gnt_count   = 0;
        req_cycles  = 0;
        first_gnt   = -1;
        first_valid = -1;
        last_req_len = 0;
        last_gnt_addr = 32'hFFFF_FFFF;
    endtask

    // Memory, program counter and reference model; checks every cycle.
    initial begin
        pc_in       = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            logic take;
            @(negedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                q.delete();
                pend_live = 1'b0;
                pc_reg    = '0;
                req_age   = 0;
            end
            if (!mon_en) q.delete();
            pc_in = pc_reg;
            if (pend) pend_age++;
            imem_rvalid = pend && pend_age >= pend_delay;
            imem_rdata  = imem_rvalid ? instr_of(pend_addr) : 32'hDEAD_BEEF;
            imem_gnt    = imem_req && req_age >= gnt_delay;
            take        = imem_rvalid && pend_live;
            #1;
            if (mon_en && rst_n) begin
                chk("valid", id_valid, q.size() > 0);
                if (q.size() > 0) begin
                    chk("id_pc", id_pc, q[0].pc);
                    chk("id_instr", id_instr, q[0].instr);
`ifdef FETCH_MISALIGN_CHECK_EN
                    chk("id_mis", id_misaligned, 1'b0);
`endif
                end else begin
                    chk("empty_nop", id_instr, NOP);
                end
                if (imem_req) chk("slot_rsv", q.size() < DEPTH, 1'b1);
            end
            chk("pc_adv", pc_advance, imem_req && imem_gnt && !flush);
            if (imem_req) begin
                chk("req_addr", imem_addr, pc_reg);
                chk("one_outst", pend, 1'b0);
            end
            if (pc_advance) adv_count++;
            if (imem_req) req_cycles++;
            if (imem_rvalid) pend = 1'b0;
            if (imem_req && imem_gnt) begin
                gnt_count++;
                if (first_gnt < 0) first_gnt = cyc;
                last_gnt_addr = imem_addr;
                last_req_len  = req_age + 1;
                pend       = 1'b1;
                pend_age   = 0;
                pend_delay = rsp_delay;
                pend_addr  = imem_addr;
                pend_live  = rst_n;
            end
            if (flush) pend_live = 1'b0;
            req_age = (imem_req && !imem_gnt) ? req_age + 1 : 0;
            if (rst_n && id_valid && first_valid < 0) first_valid = cyc;
            if (rst_n && id_valid && id_ready) begin
                seen_pc.push_back(id_pc);
                seen_instr.push_back(id_instr);
                seen_cyc.push_back(cyc);
            end
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (id_ready && q.size() > 0) void'(q.pop_front());
                if (take) q.push_back('{pend_addr, instr_of(pend_addr)});
            end
            if (!rst_n) pc_reg = '0;
            else if (flush) pc_reg = flush_target;
            else if (pc_advance) pc_reg = pc_reg + 32'd4;
        end
    end

    task automatic cyc3();
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset(input int gd, input int rd, input logic rdy);
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b0;
        id_ready  = rdy;
        gnt_delay = gd;
        rsp_delay = rd;
        #3;
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        #3;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_adv"}, pc_advance, 1'b0);
        chk({tag, "_valid"}, id_valid, 1'b0);
        chk({tag, "_instr"}, id_instr, NOP);
        chk({tag, "_pc"}, id_pc, 32'h0);
    endtask

    initial begin
        int snap_req, snap_adv;
        rst_n = 1'b0;
        flush = 1'b0;
        id_ready = 1'b0;
        flush_target = '0;
        gnt_delay = 0;
        rsp_delay = 1;
        mon_en = 1'b1;
        clear_logs();
        repeat (2) cyc3();
        chk_reset_vals("rst");

        // In-order fetch at minimum latency
        do_reset(0, 1, 1'b1);
        for (int i = 0; i < 60 && seen_pc.size() < 3; i++) cyc3();
        chk("t1_cnt", 32'(seen_pc.size()), 32'd3);
        chk("t1_pc0", seen_pc[0], 32'd0);
        chk("t1_pc1", seen_pc[1], 32'd4);
        chk("t1_pc2", seen_pc[2], 32'd8);
        chk("t1_ins1", seen_instr[1], 32'h0004_0113);
        chk("t1_lat", 32'(first_valid - first_gnt), 32'd2);
        chk("t1_gap", 32'(seen_cyc[1] - seen_cyc[0]), 32'd3);
        chk("t1_adv", 32'(adv_count), 32'(gnt_count));

        // Back-pressure fills exactly two slots
        do_reset(0, 1, 1'b0);
        repeat (7) cyc3();
        snap_req = req_cycles;
        repeat (8) cyc3();
        chk("t2_noreq", 32'(req_cycles), 32'(snap_req));
        chk("t2_adv", 32'(adv_count), 32'd2);
        chk("t2_pc", pc_reg, 32'd8);
        chk("t2_head", id_pc, 32'd0);
        @(negedge clk);
        id_ready = 1'b1;
        #3;
        for (int i = 0; i < 60 && seen_pc.size() < 3; i++) cyc3();
        chk("t2_pc0", seen_pc[0], 32'd0);
        chk("t2_pc1", seen_pc[1], 32'd4);
        chk("t2_pc2", seen_pc[2], 32'd8);
        chk("t2_gap", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);

        // Grant delayed three cycles
        do_reset(3, 1, 1'b1);
        for (int i = 0; i < 20 && gnt_count < 1; i++) cyc3();
        chk("t3_len", 32'(last_req_len), 32'd4);
        chk("t3_adv", 32'(adv_count), 32'd1);
        chk("t3_addr", last_gnt_addr, 32'd0);
        for (int i = 0; i < 20 && seen_pc.size() < 1; i++) cyc3();
        chk("t3_pc0", seen_pc[0], 32'd0);
        chk("t3_adv2", 32'(adv_count), 32'd1);

        // Flush while waiting for the response to address 8
        do_reset(0, 3, 1'b1);
        for (int i = 0; i < 80 && gnt_count < 3; i++) cyc3();
        chk("t4_gaddr", last_gnt_addr, 32'd8);
        @(negedge clk);
        flush = 1'b1;
        flush_target = 32'd100;
        #3;
        chk("t4_norv", imem_rvalid, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #3;
        chk("t4_clr", id_valid, 1'b0);
        for (int i = 0; i < 80 && seen_pc.size() < 3; i++) cyc3();
        chk("t4_pc1", seen_pc[1], 32'd4);
        chk("t4_pc2", seen_pc[2], 32'd100);
        chk("t4_ins2", seen_instr[2], 32'h0064_0113);
        chk("t4_gnt", last_gnt_addr, 32'd100);

        // Flush in the same cycle as the grant
        do_reset(2, 1, 1'b1);
        for (int i = 0; i < 10 && req_cycles < 1; i++) cyc3();
        cyc3();
        @(negedge clk);
        flush = 1'b1;
        flush_target = 32'd200;
        #3;
        chk("t5_gnt", imem_gnt, 1'b1);
        chk("t5_adv", pc_advance, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #3;
        chk("t5_rv", imem_rvalid, 1'b1);
        chk("t5_stale", id_valid, 1'b0);
        for (int i = 0; i < 40 && seen_pc.size() < 1; i++) cyc3();
        chk("t5_pc0", seen_pc[0], 32'd200);
        chk("t5_gcnt", 32'(gnt_count), 32'd2);
        chk("t5_acnt", 32'(adv_count), 32'd1);

        // Reset with a response outstanding
        do_reset(0, 2, 1'b1);
        for (int i = 0; i < 10 && gnt_count < 1; i++) cyc3();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        chk_reset_vals("t6");
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("t6_late", imem_rvalid, 1'b1);
        chk("t6_v1", id_valid, 1'b0);
        cyc3();
        chk("t6_v2", id_valid, 1'b0);
        for (int i = 0; i < 40 && seen_pc.size() < 1; i++) cyc3();
        chk("t6_pc0", seen_pc[0], 32'd0);
        chk("t6_ins0", seen_instr[0], 32'h0000_0113);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned target traps without touching memory
        do_reset(0, 1, 1'b0);
        repeat (3) cyc3();
        @(negedge clk);
        mon_en = 1'b0;
        flush = 1'b1;
        flush_target = 32'd102;
        #3;
        @(negedge clk);
        flush = 1'b0;
        #3;
        snap_req = req_cycles;
        snap_adv = adv_count;
        repeat (4) cyc3();
        chk("t7_valid", id_valid, 1'b1);
        chk("t7_mis", id_misaligned, 1'b1);
        chk("t7_instr", id_instr, NOP);
        chk("t7_pc", id_pc, 32'd102);
        chk("t7_req", imem_req, 1'b0);
        chk("t7_nreq", 32'(req_cycles), 32'(snap_req));
        chk("t7_nadv", 32'(adv_count), 32'(snap_adv));
        @(negedge clk);
        flush = 1'b1;
        flush_target = 32'd0;
        #3;
        @(negedge clk);
        flush = 1'b0;
        mon_en = 1'b1;
        id_ready = 1'b1;
        seen_pc.delete();
        #3;
        for (int i = 0; i < 40 && seen_pc.size() < 1; i++) cyc3();
        chk("t7_pc0", seen_pc[0], 32'd0);
`endif

        repeat (3) cyc3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
